// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - main control FSM for the multi-cycle MIPS datapath
module mips_multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_BNE   = 6'b000101,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Halt,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ERR    = 4'd15
  } state_t;

  state_t state, next_state;
  logic   branch_ne;

  // State register; reset returns to FETCH from any point in an instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Remember whether the decoded branch is BNE so BRANCH can invert the Zero test
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 branch_ne <= 1'b0;
    else if (state == DECODE)  branch_ne <= (Op == OP_BNE);
  end

  // Next-state and Moore outputs; everything held at 0 while reset is high
  always_comb begin
    next_state  = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    Halt        = 1'b0;
    State       = 4'd0;
    if (!reset) begin
      State = state;
      case (state)
        FETCH: begin
          next_state = DECODE;
          MemRead    = 1'b1;
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          ALUSrcB    = 2'b01;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          if (Op == OP_LW || Op == OP_SW)       next_state = MEMADR;
          else if (Op == OP_RTYPE)              next_state = EXEC;
          else if (Op == OP_BEQ || Op == OP_BNE) next_state = BRANCH;
          else if (Op == OP_J)                  next_state = JUMP;
          else                                  next_state = ERR;
        end
        MEMADR: begin
          next_state = (Op == OP_LW) ? MEMRD : MEMWR;
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
        end
        MEMRD: begin
          next_state = MEMWB;
          MemRead    = 1'b1;
          IorD       = 1'b1;
        end
        MEMWB: begin
          next_state = FETCH;
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
        end
        MEMWR: begin
          next_state = FETCH;
          MemWrite   = 1'b1;
          IorD       = 1'b1;
        end
        EXEC: begin
          next_state = RWB;
          ALUSrcA    = 1'b1;
          ALUOp      = 2'b10;
        end
        RWB: begin
          next_state = FETCH;
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
        end
        BRANCH: begin
          next_state  = FETCH;
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        JUMP: begin
          next_state = FETCH;
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
        end
        ERR: begin
          next_state = ERR;
          Halt       = 1'b1;
        end
        default: begin
          // Unused encodings are treated as a fault and parked in ERR
          next_state = ERR;
        end
      endcase
    end
  end

  // PC enable is the only Mealy output: branches resolve on the live ALU Zero flag
  always_comb begin
    PCEn = PCWrite | (PCWriteCond & (Zero ^ branch_ne));
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - scoreboard bench for the multi-cycle control FSM
module tb_mips_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic [3:0] st;
    logic       halt;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic [1:0] srcb;
    logic       srca;
    logic       regw;
    logic       regdst;
    logic       m2r;
    logic       irw;
    logic       memw;
    logic       memr;
    logic       iord;
    logic       pcen;
    logic       pcwc;
    logic       pcw;
  } ov_t;

  typedef struct {
    ov_t v;
    int  tag;
  } item_t;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Halt;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  int    checks;
  int    errors;
  int    cyc;
  item_t sb[$];

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .Halt(Halt), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_legal(logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_BNE || op == OP_J;
  endfunction

  // Number of cycles an instruction occupies; illegal ones are watched for 10 cycles in ERR
  function automatic int n_steps(logic [5:0] op);
    if (op == OP_LW) return 5;
    if (op == OP_SW || op == OP_RTYPE) return 4;
    if (op == OP_BEQ || op == OP_BNE || op == OP_J) return 3;
    return 12;
  endfunction

  // Reference: what the control unit must present in cycle 'step' of instruction 'op'
  function automatic ov_t model(logic [5:0] op, int step, logic z);
    ov_t o;
    o = '0;
    if (step == 0) begin
      o.st = 4'd0; o.memr = 1; o.irw = 1; o.pcw = 1; o.srcb = 2'b01; o.pcen = 1;
    end else if (step == 1) begin
      o.st = 4'd1; o.srcb = 2'b11;
    end else if (op == OP_LW || op == OP_SW) begin
      if (step == 2) begin
        o.st = 4'd2; o.srca = 1; o.srcb = 2'b10;
      end else if (op == OP_SW) begin
        o.st = 4'd5; o.memw = 1; o.iord = 1;
      end else if (step == 3) begin
        o.st = 4'd3; o.memr = 1; o.iord = 1;
      end else begin
        o.st = 4'd4; o.regw = 1; o.m2r = 1;
      end
    end else if (op == OP_RTYPE) begin
      if (step == 2) begin
        o.st = 4'd6; o.srca = 1; o.aluop = 2'b10;
      end else begin
        o.st = 4'd7; o.regw = 1; o.regdst = 1;
      end
    end else if (op == OP_BEQ || op == OP_BNE) begin
      o.st = 4'd8; o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 2'b01;
      o.pcen = (op == OP_BEQ) ? z : ~z;
    end else if (op == OP_J) begin
      o.st = 4'd9; o.pcw = 1; o.pcsrc = 2'b10; o.pcen = 1;
    end else begin
      o.st = 4'd15; o.halt = 1;
    end
    return o;
  endfunction

  task automatic do_cycle(input logic rst, input logic [5:0] op, input logic z, input ov_t exp);
    item_t it;
    @(posedge clk);
    #1;
    reset = rst;
    Op    = op;
    Zero  = z;
    cyc++;
    it.v   = exp;
    it.tag = cyc;
    sb.push_back(it);
  endtask

  task automatic reset_seq();
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, 6'($urandom), 1'($urandom), '0);
  endtask

  // zf < 0 means random Zero each cycle; rst_step >= 1 aborts the instruction with a reset there
  task automatic run_instr(input logic [5:0] op, input int zf, input int rst_step);
    int   n;
    logic z;
    n = n_steps(op);
    for (int s = 0; s < n; s++) begin
      if (s == rst_step) begin
        reset_seq();
        return;
      end
      z = (zf < 0) ? 1'($urandom) : 1'(zf);
      do_cycle(1'b0, (s == 0) ? 6'($urandom) : op, z, model(op, s, z));
    end
    if (!is_legal(op)) reset_seq();
  endtask

  // Monitor: every cycle is an output beat; pop and compare away from the active edge
  always @(negedge clk) begin
    ov_t   act;
    item_t it;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      act.st = State;      act.halt = Halt;     act.pcsrc = PCSource; act.aluop = ALUOp;
      act.srcb = ALUSrcB;  act.srca = ALUSrcA;  act.regw = RegWrite;  act.regdst = RegDst;
      act.m2r = MemtoReg;  act.irw = IRWrite;   act.memw = MemWrite;  act.memr = MemRead;
      act.iord = IorD;     act.pcen = PCEn;     act.pcwc = PCWriteCond; act.pcw = PCWrite;
      checks++;
      if (act !== it.v) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %h expected %h (State got %0d exp %0d)",
                 it.tag, act, it.v, act.st, it.v.st);
      end
    end
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    int         n;
    int         rs;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_RTYPE;
    ops[3] = OP_BEQ; ops[4] = OP_BNE; ops[5] = OP_J;
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b1;
    Op     = 6'd0;
    Zero   = 1'b0;

    reset_seq();
    run_instr(OP_LW, -1, -1);
    run_instr(OP_SW, -1, -1);
    run_instr(OP_RTYPE, -1, -1);
    run_instr(OP_BEQ, 1, -1);
    run_instr(OP_BEQ, 0, -1);
    run_instr(OP_BNE, 0, -1);
    run_instr(OP_BNE, 1, -1);
    run_instr(OP_J, -1, -1);
    run_instr(OP_LW, -1, 3);
    run_instr(OP_RTYPE, -1, -1);
    run_instr(6'b111111, -1, -1);
    run_instr(OP_BNE, 0, -1);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 12) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      n  = n_steps(op);
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, n - 1)) : -1;
      run_instr(op, -1, rs);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d beats left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
